icache_rv32: RTL and testbench
==============================

# icache_rv32

Direct-mapped instruction cache that answers the fetch addresses issued by the RV32 instruction-fetch stage. On a hit it returns the instruction in the same cycle. On a miss it asserts oStallI, which holds the fetch PC, and refills the 16-byte line from backing memory with a 4-beat burst. It sits between the IF stage (iPCADDR in, oINSTR/oStallI out) and the memory/bus side (oMemREQ/oMemADDR out, iMemDATA/iMemVALID in).

## Interface

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines × 4 words = 1 KiB).
- Derived values, not overridable: OFFSET_BITS = 4; TAG_BITS = 32 − INDEX_BITS − 4.

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iPCADDR  in  32  fetch address from IF; bits [1:0] ignored.
- iFENCEI  in  1  one-cycle pulse; invalidates every line.
- oINSTR  out  32  fetched instruction; 32'h00000013 (NOP) whenever oStallI=1.
- oStallI  out  1  fetch cannot be served this cycle; IF holds PC.
- oMemREQ  out  1  refill burst request, registered.
- oMemADDR  out  32  line base address {tag, index, 4'b0}, registered.
- iMemDATA  in  32  refill beat data.
- iMemVALID  in  1  iMemDATA valid this cycle; one beat per assertion.

## Operation

- Storage: valid[2^INDEX_BITS] (flops), tag[2^INDEX_BITS][TAG_BITS], data[2^INDEX_BITS × 4][32]. Tag and data arrays have combinational read and synchronous write.
- Address split: index = iPCADDR[INDEX_BITS+3:4]; word = iPCADDR[3:2]; tag = iPCADDR[31:INDEX_BITS+4].
- hit = (state==IDLE) & valid[index] & (tag[index]==tag). Both outputs are combinational:
  - oStallI = ~hit.
  - oINSTR = hit ? data[index][word] : NOP.
- FSM has two states:
  - IDLE:
    - On a miss with iFENCEI=0: latch index/tag into miss registers, set oMemADDR = line base, oMemREQ <= 1, beat counter <= 0, go to REFILL.
    - On a miss with iFENCEI=1: clear all valid bits and stay in IDLE; the request is re-evaluated next cycle.
  - REFILL:
    - Each cycle with iMemVALID=1: write iMemDATA to data[miss_index][cnt] and increment cnt.
    - On the beat with cnt==3: write tag[miss_index], set valid[miss_index] unless the fence_pending flag is set, oMemREQ <= 0, go to IDLE.
- Beats arrive in ascending word order 0..3. The gap between beats is arbitrary (≥0 idle cycles). oMemADDR stays constant for the whole burst.
- iMemVALID is ignored in IDLE.
- iPCADDR changes during REFILL are ignored by the refill; the refill always completes for the latched line.
- iFENCEI in IDLE clears all valid bits on the next edge.
- iFENCEI in REFILL clears all valid bits and sets fence_pending. The in-flight line is still written but not validated. fence_pending clears on the return to IDLE.
- Reset: state=IDLE, all valid=0, cnt=0, fence_pending=0, oMemREQ=0, oMemADDR=0. Tag/data arrays are not reset.
  - Consequence: oStallI=1 and oINSTR=NOP for any address until a line is filled.
  - Reset during REFILL abandons the burst. Memory must tolerate oMemREQ dropping mid-burst.

## Timing

- Hit: zero-cycle latency; oINSTR is valid in the same cycle as iPCADDR.
- Miss at cycle T:
  - oStallI=1 at T.
  - oMemREQ=1 from T+1.
  - With back-to-back beats at T+1..T+4, oMemREQ=0 and state=IDLE from T+5, and the hit is served at T+5.
  - Minimum miss penalty is 5 cycles; it grows by one per idle beat gap.
- A beat on the same edge as the REFILL→IDLE transition is the last beat. No further beat is accepted until a new request.
- A fence arriving on the same edge as the final beat counts as a fence during REFILL: the line stays invalid.

## Test plan

- Reset, then iPCADDR=0x00000000 with memory returning 0x11,0x22,0x33,0x44 on consecutive cycles → oMemREQ=1 with oMemADDR=0x0 at T+1; oStallI=1 through T+4; oINSTR=0x11 at T+5.
- After the first fill, step iPCADDR through 0x4, 0x8, 0xC → oStallI=0, oINSTR=0x22, 0x33, 0x44 with no memory request.
- Conflict miss: iPCADDR=0x400 (same index 0 with INDEX_BITS=6) → refill with oMemADDR=0x400. Then 0x0 misses again (eviction).
- Beats with 3-cycle gaps and an iMemVALID pulse asserted while in IDLE → spurious pulse ignored; miss penalty = 1 + 4×4 cycles; data correct.
- iFENCEI during IDLE after a fill → next access to 0x0 misses. iFENCEI during REFILL → burst completes, line stays invalid, immediate re-miss and second refill.
- iRST asserted after the 2nd beat → oMemREQ=0, oStallI=1 next cycle. A fresh miss restarts at beat 0 with the correct line data.

Source files
------------

// File: rtl/icache_rv32.sv
// rtl/icache_rv32.sv - direct-mapped RV32 instruction cache with 4-beat line refill
// Hits are served combinationally; misses stall fetch while the latched line is refilled.
module icache_rv32 #(
  parameter int INDEX_BITS = 6
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iPCADDR,
  input  logic        iFENCEI,
  output logic [31:0] oINSTR,
  output logic        oStallI,
  output logic        oMemREQ,
  output logic [31:0] oMemADDR,
  input  logic [31:0] iMemDATA,
  input  logic        iMemVALID
);

  localparam int OFFSET_BITS = 4;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES       = 1 << INDEX_BITS;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tagMem  [LINES];
  logic [31:0]         dataMem [LINES*4];

  logic [INDEX_BITS-1:0] pcIndex, missIndex;
  logic [TAG_BITS-1:0]   pcTag, missTag;
  logic [1:0]            pcWord, cnt;
  logic                  fencePending;
  logic                  hit, beatWr, lastBeat;
  logic                  unusedAddr;

  assign pcIndex    = iPCADDR[INDEX_BITS+3:4];
  assign pcWord     = iPCADDR[3:2];
  assign pcTag      = iPCADDR[31:INDEX_BITS+4];
  assign unusedAddr = ^iPCADDR[1:0];

  assign hit     = (state == IDLE) && valid[pcIndex] && (tagMem[pcIndex] == pcTag);
  assign oStallI = ~hit;
  assign oINSTR  = hit ? dataMem[{pcIndex, pcWord}] : NOP;

  assign beatWr   = (state == REFILL) && iMemVALID;
  assign lastBeat = beatWr && (cnt == 2'd3);

  // Arrays carry no reset; only the valid bits decide whether content is trusted.
  always_ff @(posedge iCLK) begin
    if (!iRST && beatWr)
      dataMem[{missIndex, cnt}] <= iMemDATA;
    if (!iRST && lastBeat)
      tagMem[missIndex] <= missTag;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= IDLE;
      valid        <= '0;
      cnt          <= 2'd0;
      fencePending <= 1'b0;
      oMemREQ      <= 1'b0;
      oMemADDR     <= 32'd0;
      missIndex    <= '0;
      missTag      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iFENCEI) begin
            valid <= '0;
          end else if (!hit) begin
            missIndex <= pcIndex;
            missTag   <= pcTag;
            oMemADDR  <= {pcTag, pcIndex, 4'b0000};
            oMemREQ   <= 1'b1;
            cnt       <= 2'd0;
            state     <= REFILL;
          end
        end
        REFILL: begin
          if (iFENCEI) begin
            valid        <= '0;
            fencePending <= 1'b1;
          end
          if (beatWr) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              // A fence seen at any point of the burst, including this edge, keeps the line invalid.
              if (!(fencePending || iFENCEI))
                valid[missIndex] <= 1'b1;
              fencePending <= 1'b0;
              oMemREQ      <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_rv32.sv
// tb/tb_icache_rv32.sv - directed self-checking bench for icache_rv32
module tb_icache_rv32;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iPCADDR;
  logic        iFENCEI;
  logic [31:0] oINSTR;
  logic        oStallI;
  logic        oMemREQ;
  logic [31:0] oMemADDR;
  logic [31:0] iMemDATA;
  logic        iMemVALID;

  int checks = 0;
  int errors = 0;
  int st;

  icache_rv32 #(.INDEX_BITS(6)) dut (
    .iCLK(iCLK), .iRST(iRST), .iPCADDR(iPCADDR), .iFENCEI(iFENCEI),
    .oINSTR(oINSTR), .oStallI(oStallI), .oMemREQ(oMemREQ), .oMemADDR(oMemADDR),
    .iMemDATA(iMemDATA), .iMemVALID(iMemVALID)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Backing memory contents: line base shifted up a nibble plus 0x11 per word.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    w = {30'b0, a[3:2]} + 32'd1;
    return ({a[31:4], 4'b0000} << 4) + 32'h11 * w;
  endfunction

  // Called in the miss cycle T; returns after the final beat, sampling the first post-refill cycle.
  task automatic fillLine(input logic [31:0] base, input int gap, input int fenceAt, output int stalls);
    stalls = 0;
    #1;
    stalls += int'(oStallI);
    step(); #1;
    stalls += int'(oStallI);
    check("req_rise", {31'b0, oMemREQ}, 32'd1);
    check("req_addr", oMemADDR, base);
    for (int k = 0; k < 4; k++) begin
      repeat (gap) begin
        step(); #1;
        stalls += int'(oStallI);
      end
      iMemVALID = 1'b1;
      iMemDATA  = memWord(base + 32'(4 * k));
      iFENCEI   = (k == fenceAt);
      step();
      iMemVALID = 1'b0;
      iMemDATA  = 32'd0;
      iFENCEI   = 1'b0;
      #1;
      if (k < 3) begin
        stalls += int'(oStallI);
        check("req_addr_hold", oMemADDR, base);
      end
    end
    check("req_fall", {31'b0, oMemREQ}, 32'd0);
  endtask

  initial begin
    iRST = 1'b1; iPCADDR = 32'd0; iFENCEI = 1'b0; iMemDATA = 32'd0; iMemVALID = 1'b0;
    step(); step(); #1;
    check("rst_req", {31'b0, oMemREQ}, 32'd0);
    check("rst_addr", oMemADDR, 32'd0);
    check("rst_stall", {31'b0, oStallI}, 32'd1);
    check("rst_instr", oINSTR, 32'h00000013);

    // First fill of line 0 with back-to-back beats
    iRST = 1'b0; iPCADDR = 32'h0;
    fillLine(32'h0, 0, -1, st);
    check("miss0_stalls", st, 32'd5);
    check("miss0_hit", {31'b0, oStallI}, 32'd0);
    check("miss0_instr", oINSTR, 32'h11);

    for (int i = 1; i < 4; i++) begin
      step();
      iPCADDR = 32'(4 * i);
      #1;
      check("seq_stall", {31'b0, oStallI}, 32'd0);
      check("seq_req", {31'b0, oMemREQ}, 32'd0);
      check("seq_instr", oINSTR, 32'h11 * 32'(i + 1));
    end

    // Conflict miss on index 0 then eviction of the original line
    step(); iPCADDR = 32'h400;
    fillLine(32'h400, 0, -1, st);
    check("conf_instr", oINSTR, 32'h4011);
    step(); iPCADDR = 32'h0;
    fillLine(32'h0, 0, -1, st);
    check("evict_stalls", st, 32'd5);
    check("evict_instr", oINSTR, 32'h11);

    // Spurious beat in IDLE, then a refill with 3-cycle gaps
    step(); iPCADDR = 32'h0; iMemVALID = 1'b1; iMemDATA = 32'hDEADBEEF;
    #1;
    check("spur_hit", {31'b0, oStallI}, 32'd0);
    step(); iMemVALID = 1'b0; iMemDATA = 32'd0;
    #1;
    check("spur_instr", oINSTR, 32'h11);
    check("spur_req", {31'b0, oMemREQ}, 32'd0);
    iPCADDR = 32'h10;
    fillLine(32'h10, 3, -1, st);
    check("gap_stalls", st, 32'd17);
    check("gap_instr0", oINSTR, 32'h111);
    iPCADDR = 32'h1C; #1;
    check("gap_instr3", oINSTR, 32'h144);
    iPCADDR = 32'h14; #1;
    check("gap_instr1", oINSTR, 32'h122);

    // Fence while idle invalidates a hitting line
    step(); iPCADDR = 32'h0; iFENCEI = 1'b1;
    #1;
    check("fidle_hit", {31'b0, oStallI}, 32'd0);
    step(); iFENCEI = 1'b0;
    #1;
    check("fidle_miss", {31'b0, oStallI}, 32'd1);
    fillLine(32'h0, 0, -1, st);
    check("fidle_refill", oINSTR, 32'h11);

    // Fence mid-burst and on the final beat both leave the line invalid
    step(); iPCADDR = 32'h10;
    fillLine(32'h10, 0, 1, st);
    check("fref_inval", {31'b0, oStallI}, 32'd1);
    fillLine(32'h10, 0, -1, st);
    check("fref_stalls", st, 32'd5);
    check("fref_instr", oINSTR, 32'h111);
    step(); iPCADDR = 32'h400;
    fillLine(32'h400, 0, 3, st);
    check("flast_inval", {31'b0, oStallI}, 32'd1);
    fillLine(32'h400, 0, -1, st);
    check("flast_instr", oINSTR, 32'h4011);

    // Reset after the second beat abandons the burst
    step(); iPCADDR = 32'h20;
    step(); #1;
    check("rmid_req", {31'b0, oMemREQ}, 32'd1);
    iMemVALID = 1'b1; iMemDATA = 32'hBAD00000;
    step();
    iMemDATA = 32'hBAD00001;
    step();
    iMemVALID = 1'b0; iMemDATA = 32'd0; iRST = 1'b1;
    step();
    iRST = 1'b0;
    #1;
    check("rmid_req_low", {31'b0, oMemREQ}, 32'd0);
    check("rmid_stall", {31'b0, oStallI}, 32'd1);
    fillLine(32'h20, 0, -1, st);
    check("rmid_stalls", st, 32'd5);
    check("rmid_instr0", oINSTR, 32'h211);
    iPCADDR = 32'h24; #1;
    check("rmid_instr1", oINSTR, 32'h222);
    iPCADDR = 32'h2C; #1;
    check("rmid_instr3", oINSTR, 32'h244);
    iPCADDR = 32'h0; #1;
    check("rmid_old_inval", {31'b0, oStallI}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
